// File: rtl/seven_seg_mux_driver.sv
// Four-digit multiplexed seven-segment driver: phase-accumulator scan,
// hex glyph decode and PWM anode gating, all outputs registered.
module seven_seg_mux_driver #(
    parameter logic [19:0] CNTR_STEP = 20'h00010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] disp_buf,
    input  logic [3:0]  dp,
    input  logic [7:0]  lum,
    output logic [3:0]  an_mux,
    output logic [6:0]  seg_mux,
    output logic        dp_mux
);

    logic [19:0] acc;
    logic [1:0]  idx;
    logic [7:0]  pwm_cnt;

    logic [20:0] acc_sum;
    logic        acc_carry;
    logic        pwm_on;
    logic [3:0]  nib;
    logic [6:0]  glyph;
    logic [3:0]  an_next;

    // Carry out of the 20-bit sum is the digit-advance strobe; the
    // remainder stays in acc so the long-run scan rate never drifts.
    assign acc_sum   = {1'b0, acc} + {1'b0, CNTR_STEP};
    assign acc_carry = acc_sum[20];

    assign pwm_on  = (lum == 8'hFF) | (pwm_cnt < lum);
    assign nib     = disp_buf[{idx, 2'b00} +: 4];
    assign an_next = pwm_on ? ~(4'b0001 << idx) : 4'b1111;

    always_comb begin
        glyph = 7'h7F;
        unique case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            idx     <= '0;
            pwm_cnt <= '0;
            an_mux  <= 4'b1111;
            seg_mux <= 7'h7F;
            dp_mux  <= 1'b1;
        end else begin
            acc     <= acc_sum[19:0];
            idx     <= idx + {1'b0, acc_carry};
            pwm_cnt <= pwm_cnt + 8'd1;
            // Segments stay driven while PWM blanks the anodes.
            an_mux  <= an_next;
            seg_mux <= glyph;
            dp_mux  <= ~dp[idx];
        end
    end

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Scoreboard bench for seven_seg_mux_driver: two instances with different
// scan steps checked every cycle against a cycle-count reference model.
module tb_seven_seg_mux_driver;

    localparam logic [19:0] STEP_A = 20'h02000;
    localparam logic [19:0] STEP_B = 20'h60000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] disp_buf;
    logic [3:0]  dp;
    logic [7:0]  lum;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;

    always #5 clk = ~clk;

    seven_seg_mux_driver #(.CNTR_STEP(STEP_A)) dut_a (
        .clk(clk), .rst(rst), .disp_buf(disp_buf), .dp(dp), .lum(lum),
        .an_mux(an_a), .seg_mux(seg_a), .dp_mux(dp_a)
    );

    seven_seg_mux_driver #(.CNTR_STEP(STEP_B)) dut_b (
        .clk(clk), .rst(rst), .disp_buf(disp_buf), .dp(dp), .lum(lum),
        .an_mux(an_b), .seg_mux(seg_b), .dp_mux(dp_b)
    );

    logic [6:0] glyphs [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int n_pass  = 0;
    int n_total = 0;
    int unsigned k = 0;
    logic [11:0] qa[$];
    logic [11:0] qb[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // k = number of clocks since reset released; everything follows from it.
    function automatic logic [11:0] model(input int unsigned kk,
                                          input logic [19:0] step,
                                          input logic [15:0] b,
                                          input logic [3:0] d,
                                          input logic [7:0] l);
        longint unsigned p;
        int unsigned     i;
        logic [3:0]      an;
        logic [3:0]      nib;
        p   = longint'(kk) * longint'(step);
        i   = int'((p >> 20) % 4);
        an  = 4'hF;
        if (l == 8'hFF || (kk % 256) < int'(l)) an[i] = 1'b0;
        nib = 4'((b >> (4 * i)) & 16'hF);
        return {an, glyphs[nib], ~d[i]};
    endfunction

    task automatic tick();
        if (rst) begin
            qa.push_back({4'hF, 7'h7F, 1'b1});
            qb.push_back({4'hF, 7'h7F, 1'b1});
            k = 0;
        end else begin
            qa.push_back(model(k, STEP_A, disp_buf, dp, lum));
            qb.push_back(model(k, STEP_B, disp_buf, dp, lum));
            k++;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("sb_a", {20'd0, an_a, seg_a, dp_a}, {20'd0, e});
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("sb_b", {20'd0, an_b, seg_b, dp_b}, {20'd0, e});
            end
        end
    end

    // Called one clock after reset release; checks every completed dwell.
    task automatic scan_check(input int n, input bit use_b,
                              output int changes);
        logic [3:0] prev, cur;
        int len, r, want;
        prev = use_b ? an_b : an_a;
        len = 1;
        r = 0;
        changes = 0;
        repeat (n) begin
            tick();
            cur = use_b ? an_b : an_a;
            if (cur != prev) begin
                want = use_b ? ((r % 3 == 2) ? 2 : 3) : 128;
                check(use_b ? "dwell_b" : "dwell_a", len, want);
                r++;
                changes++;
                len = 1;
                prev = cur;
            end else begin
                len++;
            end
        end
    endtask

    initial begin
        int ch, cnt;
        logic [7:0] lums [4] = '{8'h00, 8'h80, 8'hFF, 8'h01};
        int lit [4] = '{0, 512, 1024, 4};
        rst = 1'b1;
        disp_buf = '0;
        dp = '0;
        lum = '0;
        @(negedge clk);

        repeat (3) tick();
        check("rst_an", an_a, 4'b1111);
        check("rst_seg", seg_a, 7'h7F);
        check("rst_dp", dp_a, 1'b1);

        rst = 1'b0;
        disp_buf = 16'h1234;
        lum = 8'hFF;
        dp = 4'b0100;
        tick();
        check("first_an", an_a, 4'b1110);
        check("first_seg", seg_a, 7'h19);
        scan_check(4 * 128 + 10, 1'b0, ch);
        check("scan_changes_a", ch, 4);

        for (int i = 0; i < 4; i++) begin
            lum = lums[i];
            cnt = 0;
            repeat (1024) begin
                tick();
                if (an_a != 4'hF) cnt++;
            end
            check("lum_lit", cnt, lit[i]);
        end

        lum = 8'hFF;
        disp_buf = 16'hFFFF;
        repeat (512) tick();
        check("glyph_f", seg_a, 7'h0E);
        disp_buf = 16'h89AB;
        repeat (512) tick();
        repeat (50) begin
            disp_buf = 16'($urandom);
            tick();
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (300) tick();
        check("mid_idx2", an_a, 4'b1011);
        rst = 1'b1;
        tick();
        check("mid_rst_an", an_a, 4'b1111);
        check("mid_rst_seg", seg_a, 7'h7F);
        rst = 1'b0;
        tick();
        check("restart_an", an_a, 4'b1110);
        scan_check(300, 1'b0, ch);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        scan_check(999, 1'b1, ch);
        check("wrap_changes_b", ch, 374);

        repeat (3000) begin
            rst = ($urandom_range(0, 199) == 0);
            disp_buf = 16'($urandom);
            dp = 4'($urandom);
            case ($urandom_range(0, 3))
                0: lum = 8'hFF;
                1: lum = 8'h00;
                default: lum = 8'($urandom);
            endcase
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        check("queue_drained", qa.size() + qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
